// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS encoder: 8b data / 2b control to a 10b symbol, two-cycle pipeline.
// Stage 1 minimises transitions, stage 2 DC-balances against a signed running disparity.
module tmds_encoder #(
  parameter int unsigned CNT_W   = 6,
  parameter logic [9:0]  RST_SYM = 10'b1101010100
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic       de,
  output logic [9:0] tmds
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Stage 1 combinational: popcount, XOR/XNOR chain and popcount of the chain
  logic [3:0] n1d_c;
  logic       use_xnor_c;
  logic [8:0] qm_c;
  logic [3:0] n1q_c;

  always_comb begin
    n1d_c = 4'd0;
    for (int i = 0; i < 8; i++) n1d_c = n1d_c + 4'(data[i]);
    use_xnor_c = (n1d_c > 4'd4) || ((n1d_c == 4'd4) && !data[0]);
    qm_c    = '0;
    qm_c[0] = data[0];
    for (int i = 1; i < 8; i++)
      qm_c[i] = use_xnor_c ? ~(qm_c[i-1] ^ data[i]) : (qm_c[i-1] ^ data[i]);
    qm_c[8] = ~use_xnor_c;
    n1q_c = 4'd0;
    for (int i = 0; i < 8; i++) n1q_c = n1q_c + 4'(qm_c[i]);
  end

  logic [8:0] q_m;
  logic [3:0] n1q;
  logic       de_q;
  logic [1:0] ctrl_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      q_m    <= '0;
      n1q    <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      q_m    <= qm_c;
      n1q    <= n1q_c;
      de_q   <= de;
      ctrl_q <= ctrl;
    end
  end

  // Stage 2 combinational: symbol selection and disparity update
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt_c;
  logic signed [CNT_W-1:0] n1s_c, n0s_c, diff_c, bias_c, two_c;
  logic                    cnt_pos_c, cnt_neg_c, bal_c, inv_c;
  logic [9:0]              sym_c;

  always_comb begin
    two_c     = $signed(CNT_W'(2));
    n1s_c     = $signed(CNT_W'(n1q));
    n0s_c     = $signed(CNT_W'(8)) - n1s_c;
    diff_c    = n1s_c - n0s_c;
    bias_c    = q_m[8] ? two_c : '0;
    cnt_neg_c = cnt[CNT_W-1];
    cnt_pos_c = !cnt[CNT_W-1] && (cnt != '0);
    bal_c     = (cnt == '0) || (n1q == 4'd4);
    inv_c     = (cnt_pos_c && (n1q > 4'd4)) || (cnt_neg_c && (n1q < 4'd4));
    sym_c     = CTRL_00;
    cnt_nxt_c = '0;
    if (!de_q) begin
      unique case (ctrl_q)
        2'b00:   sym_c = CTRL_00;
        2'b01:   sym_c = CTRL_01;
        2'b10:   sym_c = CTRL_10;
        default: sym_c = CTRL_11;
      endcase
    end else if (bal_c) begin
      sym_c     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_nxt_c = q_m[8] ? (cnt + diff_c) : (cnt - diff_c);
    end else if (inv_c) begin
      sym_c     = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_nxt_c = cnt + bias_c - diff_c;
    end else begin
      sym_c     = {1'b0, q_m[8], q_m[7:0]};
      cnt_nxt_c = cnt - (two_c - bias_c) + diff_c;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      tmds <= RST_SYM;
      cnt  <= '0;
    end else begin
      tmds <= sym_c;
      cnt  <= cnt_nxt_c;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder: vector table with hand-computed symbols and disparity,
// plus reset sequences.
module tb_tmds_encoder;

  logic       clk_pix = 1'b0;
  logic       rst_pix_n;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic [9:0] tmds;

  tmds_encoder #(.CNT_W(6), .RST_SYM(10'b1101010100)) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .data      (data),
    .ctrl      (ctrl),
    .de        (de),
    .tmds      (tmds)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] sym;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic d, input logic [1:0] c, input logic [7:0] x,
                     input logic [9:0] s, input int n);
    vec_t v;
    v.de = d; v.ctrl = c; v.data = x; v.sym = s; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic chk_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tmds got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int exp);
    int act;
    act = int'($signed(dut.cnt));
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cnt got %0d expected %0d", name, act, exp);
    end
    checks++;
    if (act > 10 || act < -10) begin
      errors++;
      $display("FAIL %s cnt_bound got %0d expected within +-10", name, act);
    end
  endtask

  initial begin
    // Control tokens; data is junk to show it is ignored in blanking
    add(0, 2'b00, 8'hA5, 10'h354, 0);
    add(0, 2'b01, 8'h3C, 10'h0AB, 0);
    add(0, 2'b10, 8'hFF, 10'h154, 0);
    add(0, 2'b11, 8'h00, 10'h2AB, 0);
    // 0x00 stream from cnt = 0
    add(1, 2'b00, 8'h00, 10'h100, -8);
    add(1, 2'b00, 8'h00, 10'h3FF,  2);
    add(1, 2'b00, 8'h00, 10'h100, -6);
    add(1, 2'b00, 8'h00, 10'h3FF,  4);
    add(1, 2'b00, 8'h00, 10'h100, -4);
    add(1, 2'b00, 8'h00, 10'h3FF,  6);
    add(1, 2'b00, 8'h00, 10'h100, -2);
    add(1, 2'b00, 8'h00, 10'h3FF,  8);
    add(1, 2'b00, 8'h00, 10'h100,  0);
    add(1, 2'b00, 8'h00, 10'h100, -8);
    add(0, 2'b00, 8'h77, 10'h354,  0);
    // 0xFF stream (XNOR path)
    add(1, 2'b00, 8'hFF, 10'h200, -8);
    add(1, 2'b00, 8'hFF, 10'h0FF, -2);
    add(1, 2'b00, 8'hFF, 10'h0FF,  4);
    add(1, 2'b00, 8'hFF, 10'h200, -4);
    add(0, 2'b11, 8'h12, 10'h2AB,  0);
    // Five active pixels, one blanking cycle, then active again from cnt = 0
    add(1, 2'b00, 8'h00, 10'h100, -8);
    add(1, 2'b00, 8'h00, 10'h3FF,  2);
    add(1, 2'b00, 8'h00, 10'h100, -6);
    add(1, 2'b00, 8'h00, 10'h3FF,  4);
    add(1, 2'b00, 8'h00, 10'h100, -4);
    add(0, 2'b01, 8'hC3, 10'h0AB,  0);
    add(1, 2'b00, 8'h00, 10'h100, -8);
    // Balanced q_m and XOR/XNOR tie-break at n1d == 4
    add(1, 2'b00, 8'h10, 10'h1F0, -8);
    add(1, 2'b00, 8'h55, 10'h133, -8);
    add(1, 2'b00, 8'hAA, 10'h233, -8);
    add(1, 2'b00, 8'h01, 10'h1FF,  0);
    add(1, 2'b00, 8'h01, 10'h1FF,  8);
    add(1, 2'b00, 8'h01, 10'h300,  2);
    add(0, 2'b10, 8'h01, 10'h154,  0);

    // Reset held across clocks, with live inputs that must be ignored
    rst_pix_n = 1'b0;
    de = 1'b1; ctrl = 2'b11; data = 8'hFF;
    repeat (3) @(negedge clk_pix);
    chk_sym("reset_hold", tmds, 10'h354);
    chk_cnt("reset_hold", 0);
    de = 1'b0; ctrl = 2'b00; data = 8'h00;
    rst_pix_n = 1'b1;

    // Table: output for vecs[j-1] is visible one negedge after vecs[j] is applied
    for (int j = 0; j <= vecs.size(); j++) begin
      if (j < vecs.size()) begin
        de = vecs[j].de; ctrl = vecs[j].ctrl; data = vecs[j].data;
      end else begin
        de = 1'b0; ctrl = 2'b00; data = 8'h00;
      end
      @(negedge clk_pix);
      if (j >= 1) begin
        chk_sym($sformatf("vec%0d", j - 1), tmds, vecs[j-1].sym);
        chk_cnt($sformatf("vec%0d", j - 1), vecs[j-1].cnt);
      end
    end

    // Asynchronous reset mid-stream, observed without a clock edge
    de = 1'b1; data = 8'h00;
    repeat (4) @(negedge clk_pix);
    #2;
    rst_pix_n = 1'b0;
    #1;
    chk_sym("async_reset", tmds, 10'h354);
    chk_cnt("async_reset", 0);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);
    chk_sym("post_reset0", tmds, 10'h354);
    chk_cnt("post_reset0", 0);
    @(negedge clk_pix);
    chk_sym("post_reset1", tmds, 10'h100);
    chk_cnt("post_reset1", -8);
    @(negedge clk_pix);
    chk_sym("post_reset2", tmds, 10'h3FF);
    chk_cnt("post_reset2", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Single-channel DVI 1.0 TMDS encoder. Sits directly downstream of the 720p video timing generator and pixel-colour logic in the HDMI path.
- Converts one 8-bit colour component plus 2 control bits and the data-enable into a 10-bit TMDS symbol per pixel clock.
- The top level instantiates three copies, one each for B, G and R. The blue channel carries ctrl = {vsync, hsync}. The 10-bit outputs feed the 10:1 serializers.

Parameters:
- CNT_W, 6, width of the signed running-disparity counter; must be ≥ 5.
- RST_SYM, 10'b1101010100, symbol driven on tmds while reset is asserted (the ctrl=00 token).

Ports:
- clk_pix  in  1  pixel clock; all logic is on the rising edge.
- rst_pix_n  in  1  asynchronous, active-low reset.
- data  in  8  colour component, valid when de=1.
- ctrl  in  2  control bits {c1,c0}, used when de=0.
- de  in  1  data enable; high during active video.
- tmds  out  10  encoded symbol; bit 0 is transmitted first.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_pix_n=0), effective immediately regardless of clock:
  - tmds = RST_SYM;
  - disparity counter cnt = 0;
  - all pipeline registers cleared, with de_q=0 and ctrl_q=00.
  - Reset asserted mid-line aborts encoding. The first symbol after release comes from data sampled after release.
- Latency: exactly 2 clk_pix cycles from inputs to tmds. Fully pipelined, one symbol per cycle, no stalls.
- Stage 1 (registered), transition minimisation:
  - n1d = popcount(data).
  - If n1d > 4, or n1d == 4 and data[0] == 0, use XNOR:
    - q_m[0] = data[0];
    - q_m[i] = ~(q_m[i-1] ^ data[i]);
    - q_m[8] = 0.
  - Otherwise use XOR:
    - q_m[i] = q_m[i-1] ^ data[i];
    - q_m[8] = 1.
  - Register q_m[8:0], n1q = popcount(q_m[7:0]), de and ctrl.
  - Define n0q = 8 − n1q.
- Stage 2 (registered), DC balancing. cnt is signed CNT_W; all differences are sign-extended before adding.
  - de_q=1 and (cnt == 0 or n1q == n0q):
    - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m[8] ? (n1q − n0q) : (n0q − n1q).
  - de_q=1 and ((cnt > 0 and n1q > n0q) or (cnt < 0 and n0q > n1q)):
    - tmds = {1, q_m[8], ~q_m[7:0]};
    - cnt += 2·q_m[8] + (n0q − n1q).
  - de_q=1, all other cases:
    - tmds = {0, q_m[8], q_m[7:0]};
    - cnt += −2·(~q_m[8]) + (n1q − n0q).
  - de_q=0: cnt = 0, and tmds is set from ctrl_q:
    - 00 → 1101010100
    - 01 → 0010101011
    - 10 → 0101010100
    - 11 → 1010101011
- Boundaries:
  - |cnt| ≤ 10 for any input stream; CNT_W=6 cannot overflow.
  - A de toggle on consecutive cycles is handled per-cycle with no extra gap.
  - The first active pixel after blanking always starts with cnt = 0.
  - Inputs X while de=0 must not propagate to tmds (data is unused in blanking).

Test Plan:
- Reset: hold rst_pix_n=0, toggle clk_pix → tmds = 1101010100, cnt = 0. Assert reset asynchronously mid-pattern → tmds = 1101010100 immediately, without a clock edge.
- Control tokens: de=0, ctrl = 00, 01, 10, 11 on successive cycles → tmds two cycles later = 1101010100, 0010101011, 0101010100, 1010101011.
- Data 0x00 stream: de=1 from cnt=0 → tmds alternates 0x100, 0x3FF, 0x100, … with cnt sequence −8, 2, −6, 4, −4, 6, −2, 8, 0, −8. Check cnt never exceeds ±10.
- Data 0xFF: de=1 from cnt=0 (XNOR path) → tmds = 0x200 (10_0000_0000), cnt = −8. Check the next symbol against a golden model.
- Blanking reset of disparity: run 5 active 0x00 pixels, then de=0 for 1 cycle, then 0x00 → the first active symbol after blanking is 0x100 (cnt restarted at 0).
- Random regression: 100k random data/ctrl/de values, plus a full 1650×750 frame driven by the timing generator, compared against a reference encoder model. Additionally decode tmds back and check data == original, delayed by 2 cycles.
